// File: rtl/dmem_pkg.sv
// Shared types and width helpers for the data-memory controller.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    typedef enum logic [1:0] {HIT_RAM, HIT_MMIO, HIT_NONE} hit_e;

    function automatic int lane_cnt(input int data_w);
        return data_w / 8;
    endfunction

    // Byte-offset bits inside one data word.
    function automatic int lsb_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Index width, never narrower than one bit so single-entry arrays still work.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_ctrl_be_ram.sv
// Byte-lane-write RAM with a registered read port; contents survive reset.
module be_ram #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = 6
) (
    input  logic                clk,
    input  logic                we,
    input  logic                re,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/ready request, programmable wait states,
// RAM plus a small MMIO register window, error response for unmapped addresses.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH_WORDS = 64,
    parameter int                WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter int                MMIO_REGS   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    input  logic [DATA_W/8-1:0]           req_be,
    output logic                          resp_valid,
    output logic [DATA_W-1:0]             resp_rdata,
    output logic                          resp_err,
    output logic [MMIO_REGS*DATA_W-1:0]   mmio_out
);

    localparam int NB      = lane_cnt(DATA_W);
    localparam int LSB     = lsb_w(DATA_W);
    localparam int RAM_AW  = $clog2(DEPTH_WORDS) + LSB;
    localparam int MMIO_AW = $clog2(MMIO_REGS) + LSB;
    localparam int RIDX_W  = idx_w(DEPTH_WORDS);
    localparam int MIDX_W  = idx_w(MMIO_REGS);

    state_e state, nstate;
    logic [3:0] cnt;

    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [NB-1:0]     lat_be;

    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [NB-1:0]     c_be;
    hit_e              c_hit;
    logic [RIDX_W-1:0] c_ridx;
    logic [MIDX_W-1:0] c_midx;

    logic accept, commit;
    hit_e hit_q;
    logic ld_q;
    logic [DATA_W-1:0] mmio_rd_q, ram_rdata;
    logic [MMIO_REGS-1:0][DATA_W-1:0] mmio_q;

    assign accept = req_valid && req_ready;
    // With zero wait states the commit edge is the acceptance edge itself.
    assign commit = (state == IDLE && accept && WAIT_STATES == 0) ||
                    (state == WAIT && cnt == '0);

    always_comb begin
        if (state == IDLE) begin
            c_we = req_we;  c_addr = req_addr;  c_wdata = req_wdata;  c_be = req_be;
        end else begin
            c_we = lat_we;  c_addr = lat_addr;  c_wdata = lat_wdata;  c_be = lat_be;
        end
        c_hit = HIT_NONE;
        if ((c_addr >> RAM_AW) == '0)
            c_hit = HIT_RAM;
        else if ((c_addr >> MMIO_AW) == (MMIO_BASE >> MMIO_AW))
            c_hit = HIT_MMIO;
        c_ridx = RIDX_W'((c_addr >> LSB) & ADDR_W'(DEPTH_WORDS - 1));
        c_midx = MIDX_W'((c_addr >> LSB) & ADDR_W'(MMIO_REGS - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (accept) nstate = (WAIT_STATES == 0) ? RESP : WAIT;
            WAIT:    if (cnt == '0) nstate = RESP;
            RESP:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        resp_err   = resp_valid && (hit_q == HIT_NONE);
        resp_rdata = '0;
        if (resp_valid && ld_q) begin
            if (hit_q == HIT_RAM)       resp_rdata = ram_rdata;
            else if (hit_q == HIT_MMIO) resp_rdata = mmio_rd_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            hit_q     <= HIT_NONE;
            ld_q      <= 1'b0;
            mmio_rd_q <= '0;
            mmio_q    <= '0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
                cnt       <= (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                hit_q     <= c_hit;
                ld_q      <= !c_we;
                mmio_rd_q <= mmio_q[c_midx];
                if (c_we && c_hit == HIT_MMIO) begin
                    for (int i = 0; i < NB; i++) begin
                        if (c_be[i]) mmio_q[c_midx][8*i +: 8] <= c_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    assign mmio_out = mmio_q;

    be_ram #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (RIDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (commit && c_we && c_hit == HIT_RAM),
        .re    (commit && !c_we && c_hit == HIT_RAM),
        .addr  (c_ridx),
        .wdata (c_wdata),
        .be    (c_be),
        .rdata (ram_rdata)
    );

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised data-memory controller that replaces the fixed single-cycle data RAM in the core-plus-memories integration.
- Accepts load/store requests from the core over a valid/ready handshake.
- Supports per-byte write enables and a configurable number of wait states.
- Decodes a small MMIO register window alongside the RAM.
- Flags accesses to unmapped addresses with an error response.

Parameters:
ADDR_W, 32, request address width
DATA_W, 32, data width; must be a multiple of 8
DEPTH_WORDS, 64, RAM depth in DATA_W words; power of two
WAIT_STATES, 1, extra cycles between acceptance and response; 0..15
MMIO_BASE, 32'hFFFF_0000, byte base address of MMIO window; aligned to the window size
MMIO_REGS, 4, number of DATA_W MMIO registers; power of two, at least 1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address; low log2(DATA_W/8) bits ignored
req_wdata  in  DATA_W  store data, lane-aligned
req_be  in  DATA_W/8  byte lane enables for stores
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  DATA_W  load data (0 for stores and errors)
resp_err  out  1  address unmapped; qualified by resp_valid
mmio_out  out  MMIO_REGS*DATA_W  MMIO register contents, reg 0 in the LSBs

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - state = IDLE
  - req_ready = 1 while IDLE
  - resp_valid, resp_rdata, resp_err = 0
  - wait counter = 0
  - all MMIO registers = 0
  - RAM array is not reset
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready the request (we, addr, wdata, be) is latched.
  - If WAIT_STATES == 0, next state is RESP; otherwise next state is WAIT with counter = WAIT_STATES-1.
- WAIT:
  - req_ready = 0.
  - Counter decrements each cycle.
  - When counter == 0, next state is RESP.
- Commit edge (entry into RESP):
  - Address decode: RAM hit when addr < DEPTH_WORDS*DATA_W/8. MMIO hit when addr falls in [MMIO_BASE, MMIO_BASE + MMIO_REGS*DATA_W/8). Anything else is an error.
  - Store, RAM hit: each byte lane with be[i] = 1 is written; other lanes are unchanged. be = 0 is a legal no-op.
  - Store, MMIO hit: same lane merge into the addressed register.
  - Load: resp_rdata is registered from the addressed word. be is ignored for loads.
  - Error: no state change; resp_err = 1; resp_rdata = 0.
- RESP:
  - resp_valid = 1 for exactly one cycle.
  - req_ready = 0.
  - Next state is IDLE.
  - resp_valid, resp_err and resp_rdata return to 0 in IDLE.
- Latency and throughput:
  - Acceptance edge to resp_valid high is WAIT_STATES+1 cycles.
  - One request per WAIT_STATES+2 cycles.
  - No response backpressure: the core must sample resp on the resp_valid cycle.
- req_valid held while req_ready = 0 is ignored; no queueing.
- Read-after-write: a load accepted after a store's RESP cycle returns the new data.
- Address arithmetic:
  - Word index = addr[log2(DEPTH_WORDS)+log2(DATA_W/8)-1 : log2(DATA_W/8)].
  - High address bits must be zero for a RAM hit. There is no aliasing or wrap-around; out-of-range addresses are errors.
- Reset asserted mid-operation:
  - Immediate return to IDLE.
  - A latched but uncommitted store is discarded.
  - No resp_valid is produced.
  - MMIO registers clear; RAM retains its contents.

Decomposition:
- Package dmem_pkg holds:
  - state_e enum (IDLE, WAIT, RESP)
  - localparam functions for byte-lane count and index widths
  - decode result enum (HIT_RAM, HIT_MMIO, HIT_NONE)
- Sub-module be_ram holds the DEPTH_WORDS x DATA_W array:
  - synchronous byte-enable write
  - registered read
  - no reset

Test Plan:
- WAIT_STATES=1: store addr 0x10, wdata 0xDEADBEEF, be 4'hF; then load 0x10 -> resp_valid exactly 2 cycles after each acceptance; rdata 0xDEADBEEF; resp_err 0; req_ready low for 2 cycles after each acceptance.
- Byte merge: RAM word at 0x20 = 0x11223344; store wdata 0xAABBCCDD, be 4'b0101; load -> 0x11BB33DD.
- WAIT_STATES=0 back-to-back: req_valid held high with 4 loads -> one acceptance every 2 cycles; each resp_valid pulse is 1 cycle wide.
- Unmapped: store to 0x0000_1000 (DEPTH_WORDS=64), then load 0x0000_1000 -> resp_err 1 and rdata 0 for both; RAM and MMIO unchanged.
- MMIO: store 0x5A to MMIO_BASE+4 with be 4'h1 -> mmio_out[63:32] = 0x0000005A after the commit edge; load MMIO_BASE+4 -> 0x5A.
- Reset mid-op: WAIT_STATES=3, store 0xCAFEF00D to 0x30; assert reset in the 2nd WAIT cycle -> no resp_valid; req_ready 1 immediately; mmio_out 0; subsequent load 0x30 returns the old value.
